sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. Width, depth, watermark thresholds and read mode (registered or first-word-fall-through) are all configurable. It adds occupancy count, almost-full/almost-empty watermarks and sticky overflow/underflow error flags. It sits between a producer and a consumer in one clock domain and keeps the familiar write_*/read_* port set.

---
 rtl/sync_fifo_param_if.sv | 33 +++
 rtl/sync_fifo_param.sv | 104 ++++++++++
 tb/tb_sync_fifo_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for the single-clock FIFO
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  write_full;
    logic                  read_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side: drives requests, observes status and payload
    modport master (
        output write_en, write_data, read_en, err_clr,
        input  read_data, read_valid, write_full, read_empty,
        input  almost_full, almost_empty, count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  write_en, write_data, read_en, err_clr,
        output read_data, read_valid, write_full, read_empty,
        output almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with watermarks, sticky errors and optional FWFT
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_q;
    logic                  unf_q;

    // Every flag comes from the registered count, i.e. state at cycle start
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign wr_acc = bus.write_en & ~full;
    assign rd_acc = bus.read_en & ~empty;

    // Storage write; not reset, and writes during reset are dropped
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr] <= bus.write_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.write_en && full)   ovf_q <= 1'b1;
            else if (bus.err_clr)       ovf_q <= 1'b0;
            if (bus.read_en && empty)   unf_q <= 1'b1;
            else if (bus.err_clr)       unf_q <= 1'b0;
        end
    end

    assign bus.write_full   = full;
    assign bus.read_empty   = empty;
    assign bus.almost_full  = (cnt >= AF_CNT);
    assign bus.almost_empty = (cnt <= AE_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: payload lands one cycle after the accepted pop
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr];
                end
            end

            assign bus.read_data  = rd_data_q;
            assign bus.read_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Head word is shown directly; zero while empty so reset reads as 0
            assign bus.read_data  = empty ? '0 : mem[rd_ptr];
            assign bus.read_valid = ~empty;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed table and sequence bench for sync_fifo_param
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
        u_reg (.clk(clk), .rst(rst), .bus(if0));
    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
        u_fwft (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic       rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic rst_n, input logic we, input logic [7:0] wd,
                                input logic re, input logic clr, input logic [4:0] cnt,
                                input logic full, input logic empty, input logic af,
                                input logic ae, input logic ovf, input logic unf,
                                input logic rv, input logic [7:0] rd);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.wd = wd; v.re = re; v.clr = clr;
        v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.rv = rv; v.rd = rd;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        if0.write_en = we; if0.write_data = wd; if0.read_en = re; if0.err_clr = clr;
    endtask

    task automatic drive1(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        if1.write_en = we; if1.write_data = wd; if1.read_en = re; if1.err_clr = clr;
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_count"}, 32'(if0.count), 0);
        check({tag, "_empty"}, 32'(if0.read_empty), 1);
        check({tag, "_full"}, 32'(if0.write_full), 0);
        check({tag, "_ae"}, 32'(if0.almost_empty), 1);
        check({tag, "_af"}, 32'(if0.almost_full), 0);
        check({tag, "_rv"}, 32'(if0.read_valid), 0);
        check({tag, "_rd"}, 32'(if0.read_data), 0);
        check({tag, "_ovf"}, 32'(if0.overflow), 0);
        check({tag, "_unf"}, 32'(if0.underflow), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        drive0(0, 8'h00, 0, 0);
        drive1(0, 8'h00, 0, 0);

        // Table: reset, fill, overflow, drain, underflow, error clearing
        add(0, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            add(1, 1, 8'(i + 1), 0, 0, 5'(i + 1), (i == 15), 0, (i + 1 >= 14), (i + 1 <= 2),
                0, 0, 0, 8'h00);
        end
        add(1, 1, 8'h11, 0, 0, 5'd16, 1, 0, 1, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < 16; j++) begin
            add(1, 0, 8'h00, 1, 0, 5'(15 - j), 0, (j == 15), (15 - j >= 14), (15 - j <= 2),
                1, 0, 1, 8'(j + 1));
        end
        add(1, 0, 8'h00, 1, 0, 5'd0, 0, 1, 0, 1, 1, 1, 0, 8'h10);
        add(1, 0, 8'h00, 0, 1, 5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h10);
        add(1, 0, 8'h00, 1, 1, 5'd0, 0, 1, 0, 1, 0, 1, 0, 8'h10);
        add(1, 0, 8'h00, 0, 1, 5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h10);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst_n;
            drive0(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].clr);
            step();
            check($sformatf("v%0d_count", i), 32'(if0.count), 32'(tbl[i].cnt));
            check($sformatf("v%0d_full", i), 32'(if0.write_full), 32'(tbl[i].full));
            check($sformatf("v%0d_empty", i), 32'(if0.read_empty), 32'(tbl[i].empty));
            check($sformatf("v%0d_af", i), 32'(if0.almost_full), 32'(tbl[i].af));
            check($sformatf("v%0d_ae", i), 32'(if0.almost_empty), 32'(tbl[i].ae));
            check($sformatf("v%0d_ovf", i), 32'(if0.overflow), 32'(tbl[i].ovf));
            check($sformatf("v%0d_unf", i), 32'(if0.underflow), 32'(tbl[i].unf));
            check($sformatf("v%0d_rv", i), 32'(if0.read_valid), 32'(tbl[i].rv));
            check($sformatf("v%0d_rd", i), 32'(if0.read_data), 32'(tbl[i].rd));
        end
        drive0(0, 8'h00, 0, 0);

        // Sequence: steady-state read+write at count 5 across pointer wraps
        rst = 0;
        step();
        rst = 1;
        for (int k = 0; k < 5; k++) begin
            drive0(1, 8'(8'h20 + k), 0, 0);
            q.push_back(8'(8'h20 + k));
            step();
        end
        check("pre_rw_count", 32'(if0.count), 5);
        for (int k = 0; k < 40; k++) begin
            drive0(1, 8'(8'h25 + k), 1, 0);
            q.push_back(8'(8'h25 + k));
            step();
            exp_b = q.pop_front();
            check($sformatf("rw%0d_count", k), 32'(if0.count), 5);
            check($sformatf("rw%0d_rv", k), 32'(if0.read_valid), 1);
            check($sformatf("rw%0d_rd", k), 32'(if0.read_data), 32'(exp_b));
        end
        drive0(0, 8'h00, 0, 0);

        // Sequence: reset with count 9 and overflow pending, requests ignored
        rst = 0;
        step();
        rst = 1;
        for (int k = 0; k < 17; k++) begin
            drive0(1, 8'(8'h40 + k), 0, 0);
            step();
        end
        for (int k = 0; k < 7; k++) begin
            drive0(0, 8'h00, 1, 0);
            step();
        end
        drive0(0, 8'h00, 0, 0);
        check("mid_count", 32'(if0.count), 9);
        check("mid_ovf", 32'(if0.overflow), 1);
        check("mid_rd", 32'(if0.read_data), 32'h46);
        rst = 0;
        drive0(1, 8'h99, 1, 0);
        step();
        check_reset0("rst_mid");
        rst = 1;
        drive0(0, 8'h00, 1, 0);
        step();
        check("unf_set", 32'(if0.underflow), 1);
        drive0(0, 8'h00, 0, 1);
        step();
        check("unf_clr", 32'(if0.underflow), 0);
        drive0(0, 8'h00, 0, 0);

        // Sequence: FWFT instance shows head word with zero read latency
        rst = 0;
        step();
        rst = 1;
        check("fw_rst_rv", 32'(if1.read_valid), 0);
        check("fw_rst_rd", 32'(if1.read_data), 0);
        drive1(1, 8'hA5, 0, 0);
        step();
        drive1(0, 8'h00, 0, 0);
        check("fw_a5_rd", 32'(if1.read_data), 32'hA5);
        check("fw_a5_rv", 32'(if1.read_valid), 1);
        check("fw_a5_count", 32'(if1.count), 1);
        step();
        check("fw_a5_hold", 32'(if1.read_data), 32'hA5);
        drive1(0, 8'h00, 1, 0);
        step();
        check("fw_pop_empty", 32'(if1.read_empty), 1);
        check("fw_pop_rv", 32'(if1.read_valid), 0);
        drive1(1, 8'h11, 0, 0);
        step();
        drive1(1, 8'h22, 0, 0);
        step();
        drive1(0, 8'h00, 1, 0);
        check("fw_head1", 32'(if1.read_data), 32'h11);
        step();
        check("fw_head2", 32'(if1.read_data), 32'h22);
        check("fw_cnt1", 32'(if1.count), 1);
        step();
        drive1(0, 8'h00, 0, 0);
        check("fw_drained", 32'(if1.read_empty), 1);
        check("fw_unf", 32'(if1.underflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
